// File: rtl/e203_cmt_mon_pkg.sv
// rtl/e203_cmt_mon_pkg.sv - shared state encoding and default constants for the commit monitor
package e203_cmt_mon_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HIT  = 2'd1,
        ST_DONE = 2'd2,
        ST_TMO  = 2'd3
    } cmt_state_e;

    localparam logic [31:0] DEF_TOHOST_PC   = 32'h8000_0086;
    localparam int unsigned DEF_DONE_HITS   = 8;
    localparam int unsigned DEF_TIMEOUT_CYC = 10_000_000;

endpackage

// File: rtl/e203_cmt_sat_cnt.sv
// rtl/e203_cmt_sat_cnt.sv - saturating up-counter with synchronous clear and enable
module e203_cmt_sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/e203_cmt_monitor.sv
// rtl/e203_cmt_monitor.sv - commit-stream monitor: cycle/instr/hit counts and pass/fail verdict
module e203_cmt_monitor
    import e203_cmt_mon_pkg::*;
#(
    parameter int          PC_W        = 32,
    parameter int          CNT_W       = 32,
    parameter logic [31:0] TOHOST_PC   = DEF_TOHOST_PC,
    parameter int unsigned DONE_HITS   = DEF_DONE_HITS,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             cmt_valid,
    input  logic [PC_W-1:0]  cmt_pc,
    input  logic             disp_valid,
    input  logic             disp_ready,
    input  logic [31:0]      x3_val,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [CNT_W-1:0] end_cycle,
    output logic [7:0]       hit_cnt,
    output logic             done,
    output logic             pass,
    output logic             timeout
);

    localparam logic [7:0]       LAST_HIT = 8'(DONE_HITS - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    cmt_state_e state;
    cmt_state_e state_nxt;

    logic hit;
    logic active;
    logic final_hit;
    logic tmo_hit;

    assign hit       = cmt_valid & (cmt_pc == PC_W'(TOHOST_PC));
    assign active    = (state == ST_RUN) | (state == ST_HIT);
    // hit_cnt is pre-increment here, so the hit that brings it to DONE_HITS is the final one
    assign final_hit = active & hit & (hit_cnt == LAST_HIT);
    assign tmo_hit   = active & (cycle_cnt == TMO_LAST) & ~final_hit;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (final_hit) begin
                    state_nxt = ST_DONE;
                end else if (tmo_hit) begin
                    state_nxt = ST_TMO;
                end else if (hit) begin
                    state_nxt = ST_HIT;
                end
            end
            ST_HIT: begin
                if (final_hit) begin
                    state_nxt = ST_DONE;
                end else if (tmo_hit) begin
                    state_nxt = ST_TMO;
                end
            end
            default: begin
                state_nxt = state;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else if (clr) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    e203_cmt_sat_cnt #(.W(CNT_W)) u_cycle_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .en  (active),
        .cnt (cycle_cnt)
    );

    e203_cmt_sat_cnt #(.W(CNT_W)) u_instr_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .en  ((state == ST_RUN) & disp_valid & disp_ready),
        .cnt (instr_cnt)
    );

    e203_cmt_sat_cnt #(.W(8)) u_hit_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .en  (active & hit),
        .cnt (hit_cnt)
    );

    // end_cycle is only written while still in RUN, so it holds the first hit of the run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            end_cycle <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
        end else if (clr) begin
            end_cycle <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            if ((state == ST_RUN) && hit) begin
                end_cycle <= cycle_cnt;
            end
            if (final_hit) begin
                done <= 1'b1;
                pass <= (x3_val == 32'd1);
            end else if (tmo_hit) begin
                done    <= 1'b1;
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_e203_cmt_monitor.sv
// tb/tb_e203_cmt_monitor.sv - scoreboard bench for e203_cmt_monitor
module tb_e203_cmt_monitor;

    localparam logic [31:0] TOHOST = 32'h8000_0086;
    localparam logic [31:0] BADPC  = 32'h8000_0088;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        cmt_valid = 1'b0;
    logic [31:0] cmt_pc = 32'd0;
    logic        disp_valid = 1'b0;
    logic        disp_ready = 1'b0;
    logic [31:0] x3_val = 32'd0;
    logic [31:0] cycle_cnt;
    logic [31:0] instr_cnt;
    logic [31:0] end_cycle;
    logic [7:0]  hit_cnt;
    logic        done;
    logic        pass;
    logic        timeout;

    e203_cmt_monitor #(
        .PC_W        (32),
        .CNT_W       (32),
        .TOHOST_PC   (TOHOST),
        .DONE_HITS   (8),
        .TIMEOUT_CYC (1000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .cmt_valid  (cmt_valid),
        .cmt_pc     (cmt_pc),
        .disp_valid (disp_valid),
        .disp_ready (disp_ready),
        .x3_val     (x3_val),
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt),
        .end_cycle  (end_cycle),
        .hit_cnt    (hit_cnt),
        .done       (done),
        .pass       (pass),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] cyc;
        logic [31:0] instr;
        logic [31:0] endc;
        logic [7:0]  hits;
        logic        dn;
        logic        ps;
        logic        tm;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;
    logic probe = 1'b0;
    logic done_q = 1'b0;

    function automatic exp_t mk(string n, int c, int i, int e, int h, logic d, logic p, logic t);
        exp_t r;
        r.name  = n;
        r.cyc   = 32'(c);
        r.instr = 32'(i);
        r.endc  = 32'(e);
        r.hits  = 8'(h);
        r.dn    = d;
        r.ps    = p;
        r.tm    = t;
        return r;
    endfunction

    task automatic chk(input string n, input string f, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s %s: got %0d want %0d", n, f, got, want);
        end
    endtask

    // Monitor: pops one expectation per DUT event (done rising or a probe request)
    always @(negedge clk) begin
        if (probe || (done && !done_q)) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_event: done=%0b probe=%0b with nothing queued", done, probe);
            end else begin
                mon_e = exp_q.pop_front();
                chk(mon_e.name, "cycle_cnt", cycle_cnt, mon_e.cyc);
                chk(mon_e.name, "instr_cnt", instr_cnt, mon_e.instr);
                chk(mon_e.name, "end_cycle", end_cycle, mon_e.endc);
                chk(mon_e.name, "hit_cnt", {24'd0, hit_cnt}, {24'd0, mon_e.hits});
                chk(mon_e.name, "done", {31'd0, done}, {31'd0, mon_e.dn});
                chk(mon_e.name, "pass", {31'd0, pass}, {31'd0, mon_e.ps});
                chk(mon_e.name, "timeout", {31'd0, timeout}, {31'd0, mon_e.tm});
            end
        end
        done_q = done;
    end

    task automatic step();
        @(posedge clk);
        #1;
        probe = 1'b0;
    endtask

    task automatic push(input exp_t e, input logic is_probe);
        exp_q.push_back(e);
        if (is_probe) probe = 1'b1;
    endtask

    task automatic end_test(input string n);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s: %0d expected events never appeared", n, exp_q.size());
            exp_q.delete();
        end
    endtask

    // rst is raised mid-cycle and probed before any clock edge to see the async clear
    task automatic apply_reset();
        step();
        rst        = 1'b1;
        clr        = 1'b0;
        cmt_valid  = 1'b0;
        cmt_pc     = 32'd0;
        disp_valid = 1'b0;
        disp_ready = 1'b0;
        x3_val     = 32'd0;
        push(mk("reset", 0, 0, 0, 0, 1'b0, 1'b0, 1'b0), 1'b1);
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic run_std(input string nm, input logic [31:0] x3v, input int pre,
                           input int post, input logic bad, input int exp_instr);
        exp_t e;
        apply_reset();
        x3_val = x3v;
        e = mk(nm, 241, exp_instr, 100, 8, 1'b1, (x3v == 32'd1), 1'b0);
        push(e, 1'b0);
        for (int c = 0; c < 246; c++) begin
            cmt_valid = ((c >= 100) && (c <= 240) && ((c - 100) % 20 == 0)) || (c == 243);
            cmt_pc    = TOHOST;
            if (bad && ((c == 50) || (c == 60))) begin
                cmt_valid = 1'b1;
                cmt_pc    = BADPC;
            end
            disp_valid = (c < pre) || ((c > 100) && (c <= 100 + post)) || ((c >= 60) && (c < 70));
            disp_ready = (c < pre) || ((c > 100) && (c <= 100 + post)) || ((c >= 70) && (c < 80));
            step();
        end
        cmt_valid  = 1'b0;
        disp_valid = 1'b0;
        disp_ready = 1'b0;
        e.name = {nm, "_frozen"};
        push(e, 1'b1);
        step();
        end_test(nm);
    endtask

    initial begin
        run_std("x3_pass", 32'd1, 0, 0, 1'b0, 0);
        run_std("x3_fail_disp_badpc", 32'd3, 50, 20, 1'b1, 50);

        apply_reset();
        x3_val = 32'd1;
        push(mk("timeout", 1000, 10, 0, 0, 1'b1, 1'b0, 1'b1), 1'b0);
        for (int c = 0; c < 1005; c++) begin
            cmt_valid  = (c == 1002);
            cmt_pc     = TOHOST;
            disp_valid = (c < 10);
            disp_ready = (c < 10);
            step();
        end
        cmt_valid  = 1'b0;
        disp_valid = 1'b0;
        disp_ready = 1'b0;
        push(mk("timeout_frozen", 1000, 10, 0, 0, 1'b1, 1'b0, 1'b1), 1'b1);
        step();
        end_test("timeout");

        apply_reset();
        x3_val = 32'd1;
        for (int c = 0; c < 23; c++) begin
            cmt_valid = (c >= 10) && (c <= 17);
            cmt_pc    = TOHOST;
            if (c == 17) push(mk("b2b", 18, 0, 10, 8, 1'b1, 1'b1, 1'b0), 1'b0);
            step();
            if (c == 12) push(mk("b2b_mid", 13, 0, 10, 3, 1'b0, 1'b0, 1'b0), 1'b1);
        end
        cmt_valid = 1'b0;
        step();
        end_test("b2b");

        apply_reset();
        x3_val = 32'd1;
        for (int c = 0; c <= 160; c++) begin
            cmt_valid  = (c >= 100) && ((c - 100) % 20 == 0);
            cmt_pc     = TOHOST;
            disp_valid = (c < 10);
            disp_ready = (c < 10);
            clr        = (c == 160);
            step();
        end
        clr        = 1'b0;
        cmt_valid  = 1'b0;
        disp_valid = 1'b0;
        disp_ready = 1'b0;
        push(mk("clr_on_hit", 0, 0, 0, 0, 1'b0, 1'b0, 1'b0), 1'b1);
        for (int c = 0; c < 106; c++) begin
            cmt_valid  = (c >= 30) && (c <= 100) && ((c - 30) % 10 == 0);
            cmt_pc     = TOHOST;
            disp_valid = (c < 5);
            disp_ready = (c < 5);
            if (c == 100) push(mk("clr_rerun", 101, 5, 30, 8, 1'b1, 1'b1, 1'b0), 1'b0);
            step();
        end
        cmt_valid = 1'b0;
        step();
        end_test("clr_rerun");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
